// File: rtl/exemem_skid_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, synchronous flush and a saturating stall counter.
// Latency: 1 cycle from in_fire to out_valid on an empty stage; 1 entry/cycle sustained throughput.
// Backpressure: in_ready is registered; it drops only once the skid entry is occupied, so no entry is ever lost.
module exemem_skid_reg #(
    parameter int                 DATA_W   = 141,
    parameter int                 CTRL_W   = 3,
    parameter int                 CNT_W    = 16,
    parameter logic [DATA_W-1:0]  DATA_RST = {DATA_W{1'b0}}
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ent_t m_ent;
    ent_t s_ent;
    logic m_vld;
    logic s_vld;
    logic rdy_q;

    logic in_fire;
    logic out_fire;
    logic m_free;
    ent_t in_ent;

    assign in_ent   = '{dat: in_data, ctrl: in_ctrl};
    assign in_fire  = in_valid & rdy_q;
    assign out_fire = m_vld & out_ready;
    assign m_free   = ~m_vld | out_fire;

    // rdy_q is held low through reset and mirrors ~s_vld from the first edge after release.
    assign in_ready  = rdy_q;
    assign out_valid = m_vld;
    assign out_data  = m_ent.dat;
    assign out_ctrl  = m_vld ? m_ent.ctrl : {CTRL_W{1'b0}};

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_vld     <= 1'b0;
            s_vld     <= 1'b0;
            m_ent     <= '{dat: DATA_RST, ctrl: {CTRL_W{1'b0}}};
            s_ent     <= '{dat: DATA_RST, ctrl: {CTRL_W{1'b0}}};
            rdy_q     <= 1'b0;
            stall_cnt <= {CNT_W{1'b0}};
        end else begin
            if (m_vld && !out_ready && !flush && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (flush) begin
                // The EX stage is killed too, so a same-cycle in_fire is dropped.
                m_vld      <= 1'b0;
                s_vld      <= 1'b0;
                m_ent.ctrl <= {CTRL_W{1'b0}};
                s_ent.ctrl <= {CTRL_W{1'b0}};
                rdy_q      <= 1'b1;
            end else if (m_free) begin
                if (s_vld) begin
                    m_ent <= s_ent;
                    m_vld <= 1'b1;
                    s_vld <= 1'b0;
                end else if (in_fire) begin
                    m_ent <= in_ent;
                    m_vld <= 1'b1;
                end else begin
                    m_vld <= 1'b0;
                end
                rdy_q <= 1'b1;
            end else if (in_fire) begin
                s_ent <= in_ent;
                s_vld <= 1'b1;
                rdy_q <= 1'b0;
            end else begin
                rdy_q <= ~s_vld;
            end
        end
    end

endmodule
